// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2**W x B register file, one sync write port, two async read ports (optional REG_FILE_BYPASS_EN forwarding)
module reg_file #(
  parameter int W = 5,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr_A,
  input  logic [W-1:0] r_addr_B,
  output logic [B-1:0] r_data_A,
  output logic [B-1:0] r_data_B
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] mem [DEPTH];

  // Reset clears the whole array asynchronously and overrides any write in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[w_addr] <= w_data;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd_A;
  logic fwd_B;

  // Forwarding is gated by n_reset so the outputs stay 0 while reset is held.
  assign fwd_A = n_reset && wr_en && (r_addr_A == w_addr);
  assign fwd_B = n_reset && wr_en && (r_addr_B == w_addr);

  always_comb begin
    r_data_A = fwd_A ? w_data : mem[r_addr_A];
    r_data_B = fwd_B ? w_data : mem[r_addr_B];
  end
`else
  always_comb begin
    r_data_A = mem[r_addr_A];
    r_data_B = mem[r_addr_B];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

  localparam int W = 5;
  localparam int B = 8;

  logic         clk;
  logic         n_reset;
  logic         wr_en;
  logic [W-1:0] w_addr;
  logic [B-1:0] w_data;
  logic [W-1:0] r_addr_A;
  logic [W-1:0] r_addr_B;
  logic [B-1:0] r_data_A;
  logic [B-1:0] r_data_B;

  int total;
  int bad;

  reg_file #(.W(W), .B(B)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_addr_A (r_addr_A),
    .r_addr_B (r_addr_B),
    .r_data_A (r_data_A),
    .r_data_B (r_data_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [W-1:0] wa;
    logic [B-1:0] wd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [B-1:0] exp_a;
    logic [B-1:0] exp_b;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [W-1:0] wa, input logic [B-1:0] wd,
                       input logic [W-1:0] ra, input logic [W-1:0] rb);
    wr_en    = we;
    w_addr   = wa;
    w_data   = wd;
    r_addr_A = ra;
    r_addr_B = rb;
  endtask

  logic [B-1:0] pre_exp;

  initial begin
    total = 0;
    bad   = 0;
    // Expected values are read back one edge after the inputs are applied.
    vecs[0] = '{1'b1, 5'd0,  8'd10,  5'd0,  5'd1,  8'd10,  8'd0};
    vecs[1] = '{1'b1, 5'd1,  8'd15,  5'd0,  5'd1,  8'd10,  8'd15};
    vecs[2] = '{1'b0, 5'd0,  8'd99,  5'd0,  5'd1,  8'd10,  8'd15};
    vecs[3] = '{1'b0, 5'd0,  8'd99,  5'd0,  5'd1,  8'd10,  8'd15};
    vecs[4] = '{1'b0, 5'd0,  8'd99,  5'd0,  5'd1,  8'd10,  8'd15};
    vecs[5] = '{1'b1, 5'd31, 8'hFF,  5'd31, 5'd31, 8'hFF,  8'hFF};
    vecs[6] = '{1'b1, 5'd5,  8'hA5,  5'd5,  5'd31, 8'hA5,  8'hFF};
    vecs[7] = '{1'b1, 5'd5,  8'h5A,  5'd5,  5'd0,  8'h5A,  8'd10};
    vecs[8] = '{1'b0, 5'd7,  8'h77,  5'd7,  5'd5,  8'h00,  8'h5A};
    vecs[9] = '{1'b1, 5'd16, 8'h01,  5'd16, 5'd15, 8'h01,  8'h00};

    // Reset held: writes ignored, outputs 0 even with a matching write address.
    n_reset = 1'b0;
    drive(1'b1, 5'd0, 8'd55, 5'd0, 5'd31);
    #1;
    check("reset_a_pre", r_data_A, 8'd0);
    check("reset_b_pre", r_data_B, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_a_post", r_data_A, 8'd0);
    check("reset_b_post", r_data_B, 8'd0);

    @(negedge clk);
    wr_en   = 1'b0;
    n_reset = 1'b1;
    #1;
    check("after_release_a", r_data_A, 8'd0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a", i), r_data_A, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), r_data_B, vecs[i].exp_b);
    end

    // Read-during-write to word 2 (never written, so old value 0).
    @(negedge clk);
    drive(1'b1, 5'd2, 8'd42, 5'd2, 5'd3);
    #1;
`ifdef REG_FILE_BYPASS_EN
    pre_exp = 8'd42;
`else
    pre_exp = 8'd0;
`endif
    check("rdw_a_pre_edge", r_data_A, pre_exp);
    check("rdw_b_other", r_data_B, 8'd0);
    @(posedge clk);
    #1;
    check("rdw_a_post_edge", r_data_A, 8'd42);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("rdw_a_hold", r_data_A, 8'd42);

    // Fill all words, read them back through both ports.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, W'(i), B'(i * 7 + 3), 5'd0, 5'd0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i += 4) begin
      r_addr_A = W'(i);
      r_addr_B = W'(31 - i);
      #1;
      check($sformatf("fill_a%0d", i), r_data_A, B'(i * 7 + 3));
      check($sformatf("fill_b%0d", 31 - i), r_data_B, B'((31 - i) * 7 + 3));
    end

    // Reset pulse between edges with a write pending: outputs drop at once.
    @(negedge clk);
    drive(1'b1, 5'd9, 8'h33, 5'd9, 5'd20);
    #2;
    n_reset = 1'b0;
    #1;
    check("rst_pulse_a", r_data_A, 8'd0);
    check("rst_pulse_b", r_data_B, 8'd0);
    @(posedge clk);
    #1;
    check("rst_midwrite_a", r_data_A, 8'd0);
    @(negedge clk);
    wr_en   = 1'b0;
    n_reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r_addr_A = W'(i);
      r_addr_B = W'(31 - i);
      #1;
      check($sformatf("clear_a%0d", i), r_data_A, 8'd0);
      check($sformatf("clear_b%0d", 31 - i), r_data_B, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
